// File: rtl/foc_pkg.sv
// Shared definitions for the FOC PWM back end: Q15 widths, carrier default,
// SVPWM sequencer states and the sector-number (N) encodings.
package foc_pkg;

    localparam int Q15_W          = 16;
    localparam int PWM_PERIOD_DEF = 2500;

    // Divider geometry; DIV_LAT counts from the start cycle to the valid cycle.
    localparam int DIV_LAT   = 33;
    localparam int DIV_NUM_W = 32;
    localparam int DIV_DEN_W = 18;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MUL,
        ST_SEL,
        ST_CHK,
        ST_DIV,
        ST_CMP,
        ST_OUT
    } sv_state_e;

    // N = A + 2B + 4C, where A/B/C flag strictly positive V1/V2/V3.
    localparam logic [2:0] N_S1 = 3'd3;
    localparam logic [2:0] N_S2 = 3'd1;
    localparam logic [2:0] N_S3 = 3'd5;
    localparam logic [2:0] N_S4 = 3'd4;
    localparam logic [2:0] N_S5 = 3'd6;
    localparam logic [2:0] N_S6 = 3'd2;

    function automatic logic [2:0] n_to_sector(input logic [2:0] n);
        case (n)
            N_S1:    return 3'd1;
            N_S2:    return 3'd2;
            N_S3:    return 3'd3;
            N_S4:    return 3'd4;
            N_S5:    return 3'd5;
            N_S6:    return 3'd6;
            default: return 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/svpwm_div.sv
// Unsigned 32/18 restoring divider, one numerator bit per cycle.
// Fixed DIV_LAT latency from iStart to the one-cycle oValid pulse.
module svpwm_div
    import foc_pkg::*;
(
    input  logic                 iClk,
    input  logic                 iRst_n,
    input  logic                 iStart,
    input  logic [DIV_NUM_W-1:0] iNum,
    input  logic [DIV_DEN_W-1:0] iDen,
    output logic [Q15_W-1:0]     oQuot,
    output logic                 oValid
);

    // Load edge plus one iteration per numerator bit gives the fixed latency.
    localparam int STEPS = DIV_LAT - 1;
    localparam int CNT_W = $clog2(STEPS + 1);

    logic [DIV_NUM_W-1:0] num_q, num_d;
    logic [DIV_DEN_W-1:0] den_q, den_d;
    logic [DIV_DEN_W-1:0] rem_q, rem_d;
    logic [Q15_W-1:0]     quot_q, quot_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 valid_q, valid_d;
    logic [DIV_DEN_W:0]   trial;

    // NOTE: every always_comb output gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        num_d   = num_q;
        den_d   = den_q;
        rem_d   = rem_q;
        quot_d  = quot_q;
        cnt_d   = cnt_q;
        valid_d = 1'b0;
        trial   = {rem_q, num_q[DIV_NUM_W-1]};

        if (iStart) begin
            num_d  = iNum;
            den_d  = iDen;
            rem_d  = '0;
            quot_d = '0;
            cnt_d  = CNT_W'(STEPS);
        end else if (cnt_q != '0) begin
            num_d = {num_q[DIV_NUM_W-2:0], 1'b0};
            // Quotient is known to fit 16 bits, so upper quotient bits shift out as zeros.
            if (trial >= {1'b0, den_q}) begin
                rem_d  = DIV_DEN_W'(trial - {1'b0, den_q});
                quot_d = {quot_q[Q15_W-2:0], 1'b1};
            end else begin
                rem_d  = trial[DIV_DEN_W-1:0];
                quot_d = {quot_q[Q15_W-2:0], 1'b0};
            end
            cnt_d   = cnt_q - CNT_W'(1);
            valid_d = (cnt_q == CNT_W'(1));
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            num_q   <= '0;
            den_q   <= '0;
            rem_q   <= '0;
            quot_q  <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            num_q   <= num_d;
            den_q   <= den_d;
            rem_q   <= rem_d;
            quot_q  <= quot_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
        end
    end

    assign oQuot  = quot_q;
    assign oValid = valid_q;

endmodule

// File: rtl/svpwm_duty.sv
// Space-vector PWM duty stage: sector detection, T1/T2 computation with
// overmodulation rescaling, and centre-aligned compare values for the carrier.
module svpwm_duty
    import foc_pkg::*;
#(
    parameter int PWM_PERIOD = PWM_PERIOD_DEF
) (
    input  logic             iClk,
    input  logic             iRst_n,
    input  logic             iSV_en,
    input  logic [Q15_W-1:0] iV1,
    input  logic [Q15_W-1:0] iV2,
    input  logic [Q15_W-1:0] iV3,
    output logic [Q15_W-1:0] oCmpA,
    output logic [Q15_W-1:0] oCmpB,
    output logic [Q15_W-1:0] oCmpC,
    output logic [2:0]       oSector,
    output logic             oBusy,
    output logic             oSV_done
);

    localparam logic [Q15_W-1:0]  P      = Q15_W'(PWM_PERIOD);
    localparam logic [Q15_W-1:0]  P_HALF = Q15_W'(PWM_PERIOD >> 1);
    localparam logic signed [31:0] P_S   = 32'(PWM_PERIOD);

    sv_state_e state_q, state_d;

    logic                    en_prev_q;
    logic                    start;
    logic signed [Q15_W-1:0] v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
    logic signed [16:0]      x_q, x_d, y_q, y_d, z_q, z_d;
    logic [2:0]              n_q, n_d;
    logic [Q15_W-1:0]        t1_q, t1_d, t2_q, t2_d;
    logic [17:0]             s_q, s_d;
    logic [Q15_W-1:0]        ta_q, ta_d, tb_q, tb_d, tc_q, tc_d;
    logic [Q15_W-1:0]        cmpa_q, cmpa_d, cmpb_q, cmpb_d, cmpc_q, cmpc_d;
    logic [2:0]              sector_q, sector_d;
    logic                    done_q, done_d;

    // Datapath intermediates.
    logic signed [16:0] neg_v2, neg_v3;
    logic signed [31:0] prod_x, prod_y, prod_z;
    logic signed [16:0] neg_x, neg_y, neg_z;
    logic [2:0]         n_sel;
    logic signed [16:0] t1_sel, t2_sel;
    logic [Q15_W-1:0]   t1_pos, t2_pos;
    logic [17:0]        diff;
    logic [Q15_W-1:0]   ta_cmp;

    // Divider interface.
    logic                 div_start;
    logic [DIV_NUM_W-1:0] div_num1, div_num2;
    logic [Q15_W-1:0]     quot1, quot2;
    logic                 valid1, valid2;

    function automatic logic [Q15_W-1:0] clamp_pos(input logic signed [16:0] v);
        return v[16] ? '0 : v[Q15_W-1:0];
    endfunction

    assign start = iSV_en & ~en_prev_q & (state_q == ST_IDLE);

    // Negation in 17 bits keeps -(-32768) representable.
    assign neg_v2 = 17'sd0 - {v2_q[Q15_W-1], v2_q};
    assign neg_v3 = 17'sd0 - {v3_q[Q15_W-1], v3_q};
    assign prod_x = $signed({{16{v1_q[Q15_W-1]}}, v1_q}) * P_S;
    assign prod_y = $signed({{15{neg_v3[16]}}, neg_v3}) * P_S;
    assign prod_z = $signed({{15{neg_v2[16]}}, neg_v2}) * P_S;

    assign neg_x = 17'sd0 - x_q;
    assign neg_y = 17'sd0 - y_q;
    assign neg_z = 17'sd0 - z_q;

    assign n_sel = {~v3_q[Q15_W-1] & (|v3_q),
                    ~v2_q[Q15_W-1] & (|v2_q),
                    ~v1_q[Q15_W-1] & (|v1_q)};

    always_comb begin
        t1_sel = '0;
        t2_sel = '0;
        case (n_sel)
            N_S1: begin t1_sel = neg_z; t2_sel = x_q;   end
            N_S2: begin t1_sel = z_q;   t2_sel = y_q;   end
            N_S3: begin t1_sel = x_q;   t2_sel = neg_y; end
            N_S4: begin t1_sel = neg_x; t2_sel = z_q;   end
            N_S5: begin t1_sel = neg_y; t2_sel = neg_z; end
            N_S6: begin t1_sel = y_q;   t2_sel = neg_x; end
            default: begin t1_sel = '0; t2_sel = '0;    end
        endcase
    end

    assign t1_pos = clamp_pos(t1_sel);
    assign t2_pos = clamp_pos(t2_sel);

    // After rescaling T1+T2 never exceeds P, so the zero-vector share is non-negative.
    assign diff   = {2'b00, P} - {2'b00, t1_q} - {2'b00, t2_q};
    assign ta_cmp = Q15_W'(diff >> 1);

    assign div_num1 = {16'b0, t1_q} * {16'b0, P};
    assign div_num2 = {16'b0, t2_q} * {16'b0, P};

    svpwm_div u_div_t1 (
        .iClk   (iClk),
        .iRst_n (iRst_n),
        .iStart (div_start),
        .iNum   (div_num1),
        .iDen   (s_q),
        .oQuot  (quot1),
        .oValid (valid1)
    );

    svpwm_div u_div_t2 (
        .iClk   (iClk),
        .iRst_n (iRst_n),
        .iStart (div_start),
        .iNum   (div_num2),
        .iDen   (s_q),
        .oQuot  (quot2),
        .oValid (valid2)
    );

    always_comb begin
        state_d   = state_q;
        v1_d      = v1_q;
        v2_d      = v2_q;
        v3_d      = v3_q;
        x_d       = x_q;
        y_d       = y_q;
        z_d       = z_q;
        n_d       = n_q;
        t1_d      = t1_q;
        t2_d      = t2_q;
        s_d       = s_q;
        ta_d      = ta_q;
        tb_d      = tb_q;
        tc_d      = tc_q;
        cmpa_d    = cmpa_q;
        cmpb_d    = cmpb_q;
        cmpc_d    = cmpc_q;
        sector_d  = sector_q;
        done_d    = 1'b0;
        div_start = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    v1_d    = iV1;
                    v2_d    = iV2;
                    v3_d    = iV3;
                    state_d = ST_MUL;
                end
            end
            ST_MUL: begin
                x_d     = 17'(prod_x >>> 15);
                y_d     = 17'(prod_y >>> 15);
                z_d     = 17'(prod_z >>> 15);
                state_d = ST_SEL;
            end
            ST_SEL: begin
                n_d     = n_sel;
                t1_d    = t1_pos;
                t2_d    = t2_pos;
                s_d     = {2'b00, t1_pos} + {2'b00, t2_pos};
                state_d = ST_CHK;
            end
            ST_CHK: begin
                if (s_q > {2'b00, P}) begin
                    div_start = 1'b1;
                    state_d   = ST_DIV;
                end else begin
                    state_d = ST_CMP;
                end
            end
            ST_DIV: begin
                // Both dividers start together and have identical latency.
                if (valid1 && valid2) begin
                    t1_d    = quot1;
                    t2_d    = quot2;
                    state_d = ST_CMP;
                end
            end
            ST_CMP: begin
                ta_d    = ta_cmp;
                tb_d    = ta_cmp + t1_q;
                tc_d    = ta_cmp + t1_q + t2_q;
                state_d = ST_OUT;
            end
            ST_OUT: begin
                case (n_q)
                    N_S1: begin cmpa_d = ta_q; cmpb_d = tb_q; cmpc_d = tc_q; end
                    N_S2: begin cmpa_d = tb_q; cmpb_d = ta_q; cmpc_d = tc_q; end
                    N_S3: begin cmpa_d = tc_q; cmpb_d = ta_q; cmpc_d = tb_q; end
                    N_S4: begin cmpa_d = tc_q; cmpb_d = tb_q; cmpc_d = ta_q; end
                    N_S5: begin cmpa_d = tb_q; cmpb_d = tc_q; cmpc_d = ta_q; end
                    N_S6: begin cmpa_d = ta_q; cmpb_d = tc_q; cmpc_d = tb_q; end
                    default: begin
                        cmpa_d = P_HALF;
                        cmpb_d = P_HALF;
                        cmpc_d = P_HALF;
                    end
                endcase
                sector_d = n_to_sector(n_q);
                done_d   = 1'b1;
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            state_q   <= ST_IDLE;
            en_prev_q <= 1'b0;
            v1_q      <= '0;
            v2_q      <= '0;
            v3_q      <= '0;
            x_q       <= '0;
            y_q       <= '0;
            z_q       <= '0;
            n_q       <= '0;
            t1_q      <= '0;
            t2_q      <= '0;
            s_q       <= '0;
            ta_q      <= '0;
            tb_q      <= '0;
            tc_q      <= '0;
            cmpa_q    <= P_HALF;
            cmpb_q    <= P_HALF;
            cmpc_q    <= P_HALF;
            sector_q  <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            en_prev_q <= iSV_en;
            v1_q      <= v1_d;
            v2_q      <= v2_d;
            v3_q      <= v3_d;
            x_q       <= x_d;
            y_q       <= y_d;
            z_q       <= z_d;
            n_q       <= n_d;
            t1_q      <= t1_d;
            t2_q      <= t2_d;
            s_q       <= s_d;
            ta_q      <= ta_d;
            tb_q      <= tb_d;
            tc_q      <= tc_d;
            cmpa_q    <= cmpa_d;
            cmpb_q    <= cmpb_d;
            cmpc_q    <= cmpc_d;
            sector_q  <= sector_d;
            done_q    <= done_d;
        end
    end

    assign oCmpA    = cmpa_q;
    assign oCmpB    = cmpb_q;
    assign oCmpC    = cmpc_q;
    assign oSector  = sector_q;
    assign oBusy    = (state_q != ST_IDLE);
    assign oSV_done = done_q;

endmodule

// File: tb/tb_svpwm_duty.sv
// Scoreboard bench for svpwm_duty: stimulus pushes hand-computed expectations,
// a monitor pops and compares on every oSV_done pulse.
module tb_svpwm_duty;

    logic        iClk   = 1'b0;
    logic        iRst_n = 1'b0;
    logic        iSV_en = 1'b0;
    logic [15:0] iV1 = '0, iV2 = '0, iV3 = '0;
    logic [15:0] oCmpA, oCmpB, oCmpC;
    logic [2:0]  oSector;
    logic        oBusy, oSV_done;

    svpwm_duty #(.PWM_PERIOD(2500)) dut (
        .iClk     (iClk),
        .iRst_n   (iRst_n),
        .iSV_en   (iSV_en),
        .iV1      (iV1),
        .iV2      (iV2),
        .iV3      (iV3),
        .oCmpA    (oCmpA),
        .oCmpB    (oCmpB),
        .oCmpC    (oCmpC),
        .oSector  (oSector),
        .oBusy    (oBusy),
        .oSV_done (oSV_done)
    );

    always #5 iClk = ~iClk;

    int cyc = 0;
    always @(posedge iClk) cyc <= cyc + 1;

    typedef struct {
        int id;
        int a;
        int b;
        int c;
        int sec;
        int done_cyc;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   done_cnt = 0;

    localparam int LAT_FAST = 5;
    localparam int LAT_DIV  = 38;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Monitor: compare every done pulse against the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge iClk);
            if (oSV_done) begin
                done_cnt++;
                if (sb.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check($sformatf("v%0d_cmpA", e.id), int'(oCmpA), e.a);
                    check($sformatf("v%0d_cmpB", e.id), int'(oCmpB), e.b);
                    check($sformatf("v%0d_cmpC", e.id), int'(oCmpC), e.c);
                    check($sformatf("v%0d_sector", e.id), int'(oSector), e.sec);
                    check($sformatf("v%0d_latency", e.id), cyc, e.done_cyc);
                end
            end
        end
    end

    // Issue one rising edge on iSV_en; the capture edge is the next posedge.
    task automatic issue(input int id, input int v1, input int v2, input int v3,
                         input int ea, input int eb, input int ec, input int es,
                         input int lat, input bit expect_done);
        exp_t e;
        iSV_en = 1'b0;
        @(posedge iClk); #1;
        iV1 = 16'(v1);
        iV2 = 16'(v2);
        iV3 = 16'(v3);
        iSV_en = 1'b1;
        if (expect_done) begin
            e.id = id; e.a = ea; e.b = eb; e.c = ec; e.sec = es;
            e.done_cyc = cyc + 1 + lat;
            sb.push_back(e);
        end
    endtask

    task automatic drain(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (sb.size() == 0) break;
            @(posedge iClk);
        end
        check("scoreboard_drained", sb.size(), 0);
        sb.delete();
    endtask

    task automatic run_vec(input int id, input int v1, input int v2, input int v3,
                           input int ea, input int eb, input int ec, input int es,
                           input int lat);
        issue(id, v1, v2, v3, ea, eb, ec, es, lat, 1'b1);
        @(posedge iClk); #1;
        iSV_en = 1'b0;
        drain(80);
        #1;
        check($sformatf("v%0d_idle_after", id), int'(oBusy), 0);
    endtask

    initial begin
        int d0;
        // Reset state.
        #23;
        check("rst_cmpA", int'(oCmpA), 1250);
        check("rst_cmpB", int'(oCmpB), 1250);
        check("rst_cmpC", int'(oCmpC), 1250);
        check("rst_sector", int'(oSector), 0);
        check("rst_busy", int'(oBusy), 0);
        check("rst_done", int'(oSV_done), 0);
        @(negedge iClk);
        iRst_n = 1'b1;
        repeat (2) @(posedge iClk);

        // Directed vectors (V1, V2, V3) -> (CmpA, CmpB, CmpC, sector).
        run_vec(0,      0,      0,      0, 1250, 1250, 1250, 0, LAT_FAST);
        run_vec(1,      0,  14188, -14188,  709, 1791, 1791, 6, LAT_FAST);
        run_vec(2,   8192,  10092, -18284,  552, 1322, 1947, 1, LAT_FAST);
        run_vec(3,  16384,  -8192,  -8192, 1250,  625, 1875, 2, LAT_FAST);
        run_vec(4,   8192, -18284,  10092, 1947,  552, 1177, 3, LAT_FAST);
        run_vec(5,  -8192, -10092,  18284, 1947, 1178,  553, 4, LAT_FAST);
        run_vec(6, -16384,   8192,   8192, 1250, 1875,  625, 5, LAT_FAST);
        run_vec(7,    100,    100,    100, 1250, 1250, 1250, 0, LAT_FAST);
        // S exactly equal to P stays on the fast path; Tc reaches P.
        run_vec(8,  16384,  16384, -32768,    0, 1250, 2500, 1, LAT_FAST);
        // Overmodulation through the divider.
        run_vec(9,  32767,  32767, -32767,    0, 1250, 2499, 1, LAT_DIV);

        // Extra edge while busy in DIV must be dropped.
        d0 = done_cnt;
        issue(10, 32767, 32767, -32767, 0, 1250, 2499, 1, LAT_DIV, 1'b1);
        @(posedge iClk); #1;
        iSV_en = 1'b0;
        repeat (8) @(posedge iClk);
        #1;
        check("busy_in_div", int'(oBusy), 1);
        iV1 = 16'(0); iV2 = 16'(14188); iV3 = 16'(-14188);
        iSV_en = 1'b1;
        @(posedge iClk); #1;
        iSV_en = 1'b0;
        drain(80);
        repeat (45) @(posedge iClk);
        check("busy_edge_one_done", done_cnt - d0, 1);

        // Reset during DIV aborts without a done pulse.
        d0 = done_cnt;
        issue(11, 32767, 32767, -32767, 0, 0, 0, 0, LAT_DIV, 1'b0);
        @(posedge iClk); #1;
        iSV_en = 1'b0;
        repeat (10) @(posedge iClk);
        #1;
        iRst_n = 1'b0;
        #1;
        check("midrst_cmpA", int'(oCmpA), 1250);
        check("midrst_cmpC", int'(oCmpC), 1250);
        check("midrst_sector", int'(oSector), 0);
        check("midrst_busy", int'(oBusy), 0);
        @(negedge iClk);
        iRst_n = 1'b1;
        repeat (45) @(posedge iClk);
        check("midrst_no_done", done_cnt - d0, 0);
        run_vec(12, 0, 14188, -14188, 709, 1791, 1791, 6, LAT_FAST);

        // Level held high for 50 cycles yields a single computation.
        d0 = done_cnt;
        issue(13, 8192, 10092, -18284, 552, 1322, 1947, 1, LAT_FAST, 1'b1);
        repeat (50) @(posedge iClk);
        #1;
        iSV_en = 1'b0;
        drain(20);
        repeat (45) @(posedge iClk);
        check("held_one_done", done_cnt - d0, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
